// File: rtl/weight_dispatch_if.sv
// Signal bundle linking the weight dispatcher, its controller and the weight RAM.
// WEIGHT_DISPATCH_BROADCAST_EN adds the broadcast request line.
interface weight_dispatch_if #(
   parameter int NUM_UNITS = 4,
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8
);
   logic                        start;
   logic [ADDR_W-1:0]           base_addr;
   logic [ADDR_W-1:0]           ram_addr;
   logic                        ram_rd;
   logic [DATA_W-1:0]           ram_out;
   logic [NUM_UNITS*DATA_W-1:0] weight_bus;
   logic [NUM_UNITS-1:0]        write_bus;
   logic                        busy;
   logic                        done;

`ifdef WEIGHT_DISPATCH_BROADCAST_EN
   logic                        broadcast;

   modport master (
      output start, base_addr, broadcast, ram_out,
      input  ram_addr, ram_rd, weight_bus, write_bus, busy, done
   );
   modport slave (
      input  start, base_addr, broadcast, ram_out,
      output ram_addr, ram_rd, weight_bus, write_bus, busy, done
   );
`else
   modport master (
      output start, base_addr, ram_out,
      input  ram_addr, ram_rd, weight_bus, write_bus, busy, done
   );
   modport slave (
      input  start, base_addr, ram_out,
      output ram_addr, ram_rd, weight_bus, write_bus, busy, done
   );
`endif
endinterface

// File: rtl/weight_dispatch.sv
// Sequences a NUM_UNITS*WPU weight block out of RAM and strobes each weight into its neuron unit.
// Optional WEIGHT_DISPATCH_BROADCAST_EN: a latched broadcast request sends WPU weights to all units.
module weight_dispatch #(
   parameter int NUM_UNITS = 4,
   parameter int DATA_W    = 8,
   parameter int WPU       = 16,
   parameter int ADDR_W    = 8
) (
   input  logic             CLOCK,
   input  logic             RESET,
   weight_dispatch_if.slave bus
);
   localparam int TOTAL = NUM_UNITS * WPU;
   localparam int K_W   = $clog2(TOTAL + 1);
   localparam int C_W   = $clog2(WPU + 1);
   localparam int U_W   = $clog2(NUM_UNITS + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t                      state_q, state_d;
   logic [ADDR_W-1:0]           base_q, base_d;
   logic [K_W-1:0]              k_q, k_d;
   logic [C_W-1:0]              cnt_q, cnt_d;
   logic [U_W-1:0]              u_q, u_d;
   logic                        drain_q, drain_d;
   logic                        bcast;
   logic [K_W-1:0]              last_k;

   logic                        vld1_q;
   logic [U_W-1:0]              tag1_q;
   logic [NUM_UNITS*DATA_W-1:0] weight_q, weight_d;
   logic [NUM_UNITS-1:0]        write_q, write_d;

`ifdef WEIGHT_DISPATCH_BROADCAST_EN
   logic bcast_q, bcast_d;
   assign bcast = bcast_q;
`else
   assign bcast = 1'b0;
`endif

   assign last_k = bcast ? K_W'(WPU - 1) : K_W'(TOTAL - 1);

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      u_d     = u_q;
      drain_d = drain_q;
`ifdef WEIGHT_DISPATCH_BROADCAST_EN
      bcast_d = bcast_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               base_d  = bus.base_addr;
               k_d     = '0;
               cnt_d   = '0;
               u_d     = '0;
               state_d = S_ISSUE;
`ifdef WEIGHT_DISPATCH_BROADCAST_EN
               bcast_d = bus.broadcast;
`endif
            end
         end
         S_ISSUE: begin
            k_d     = k_q + 1'b1;
            drain_d = 1'b0;
            if (cnt_q == C_W'(WPU - 1)) begin
               cnt_d = '0;
               u_d   = u_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            if (k_q == last_k) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            drain_d = 1'b1;
            if (drain_q) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Second pipeline stage: RAM data lands on the tagged slot one cycle after it returns.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_UNITS; gi++) begin : g_slot
         logic hit;
         assign hit                            = vld1_q && (bcast || (tag1_q == U_W'(gi)));
         assign write_d[gi]                    = hit;
         assign weight_d[gi*DATA_W +: DATA_W]  = hit ? bus.ram_out : '0;
      end
   endgenerate

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         base_q   <= '0;
         k_q      <= '0;
         cnt_q    <= '0;
         u_q      <= '0;
         drain_q  <= 1'b0;
         vld1_q   <= 1'b0;
         tag1_q   <= '0;
         weight_q <= '0;
         write_q  <= '0;
`ifdef WEIGHT_DISPATCH_BROADCAST_EN
         bcast_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         k_q      <= k_d;
         cnt_q    <= cnt_d;
         u_q      <= u_d;
         drain_q  <= drain_d;
         vld1_q   <= (state_q == S_ISSUE);
         tag1_q   <= u_q;
         weight_q <= weight_d;
         write_q  <= write_d;
`ifdef WEIGHT_DISPATCH_BROADCAST_EN
         bcast_q  <= bcast_d;
`endif
      end
   end

   assign bus.ram_rd     = (state_q == S_ISSUE);
   assign bus.ram_addr   = bus.ram_rd ? base_q + ADDR_W'(k_q) : '0;
   assign bus.busy       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
   assign bus.done       = (state_q == S_DONE);
   assign bus.weight_bus = weight_q;
   assign bus.write_bus  = write_q;
endmodule

// File: tb/tb_weight_dispatch.sv
// Directed bench for weight_dispatch: 4 units x 4 weights, RAM model returns its own address.
// Broadcast scenario runs only when WEIGHT_DISPATCH_BROADCAST_EN is defined.
module tb_weight_dispatch;
   localparam int NU  = 4;
   localparam int DW  = 8;
   localparam int WPU = 4;
   localparam int AW  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   weight_dispatch_if #(.NUM_UNITS(NU), .DATA_W(DW), .ADDR_W(AW)) bus_if ();

   weight_dispatch #(.NUM_UNITS(NU), .DATA_W(DW), .WPU(WPU), .ADDR_W(AW)) dut (
      .CLOCK (clk),
      .RESET (rst),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   // RAM model: RAM[a] = a, one-cycle read latency
   always @(posedge clk) if (bus_if.ram_rd) bus_if.ram_out <= bus_if.ram_addr;

   // Passive recorder of strobes, reads and done pulses
   logic [NU-1:0]    wb_q[$];
   logic [NU*DW-1:0] wd_q[$];
   logic [AW-1:0]    ad_q[$];
   int               done_cnt = 0;
   int               idle_bad = 0;

   always @(negedge clk) begin
      if (bus_if.write_bus != '0) begin
         wb_q.push_back(bus_if.write_bus);
         wd_q.push_back(bus_if.weight_bus);
      end else if (bus_if.weight_bus != '0) begin
         idle_bad++;
      end
      if (bus_if.done) done_cnt++;
      if (bus_if.ram_rd) ad_q.push_back(bus_if.ram_addr);
   end

   // Pulse start with a base address and count cycles from the accepting edge to done.
   task automatic do_load(input logic [7:0] base, input int mode, output int cyc);
      bus_if.base_addr = base;
      bus_if.start     = 1'b1;
      @(posedge clk); #1;
      bus_if.start     = 1'b0;
      bus_if.base_addr = 8'h00;
      cyc = 1;
      while (!bus_if.done && cyc < 100) begin
         bus_if.start = (mode == 1) && (cyc == 3 || cyc == 17 || cyc == 18);
         @(posedge clk); #1;
         cyc++;
      end
      bus_if.start = 1'b0;
      if (!bus_if.done) begin
         checks++; failures++;
         $display("FAIL load_timeout base=%h: got no done after %0d cycles, required done", base, cyc);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus_if.start = 1'b1;
      bus_if.base_addr = 8'h55;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus_if.ram_addr !== 8'h00) begin failures++; $display("FAIL reset_ram_addr: got %h required 00", bus_if.ram_addr); end
      checks++; if (bus_if.ram_rd !== 1'b0) begin failures++; $display("FAIL reset_ram_rd: got %b required 0", bus_if.ram_rd); end
      checks++; if (bus_if.weight_bus !== 32'h0) begin failures++; $display("FAIL reset_weight_bus: got %h required 0", bus_if.weight_bus); end
      checks++; if (bus_if.write_bus !== 4'h0) begin failures++; $display("FAIL reset_write_bus: got %b required 0000", bus_if.write_bus); end
      checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", bus_if.busy); end
      checks++; if (bus_if.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", bus_if.done); end
      bus_if.start = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL reset_start_not_queued: busy got %b required 0", bus_if.busy); end
      $display("test_reset: done");
   endtask

   task automatic test_load(input logic [7:0] base);
      int cyc, s0, a0, d0, i0;
      logic [7:0] d;
      s0 = wb_q.size(); a0 = ad_q.size(); d0 = done_cnt; i0 = idle_bad;
      do_load(base, 0, cyc);
      @(negedge clk); #1;
      checks++; if (cyc != 19) begin failures++; $display("FAIL load_latency base=%h: got %0d required 19", base, cyc); end
      checks++; if (wb_q.size() - s0 != 16) begin failures++; $display("FAIL load_strobes base=%h: got %0d required 16", base, wb_q.size() - s0); end
      checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL load_done_count base=%h: got %0d required 1", base, done_cnt - d0); end
      checks++; if (idle_bad != i0) begin failures++; $display("FAIL load_idle_zero base=%h: got %0d nonzero idle cycles required 0", base, idle_bad - i0); end
      for (int i = 0; i < 16; i++) begin
         d = 8'(base + 8'(i));
         if (a0 + i < ad_q.size()) begin
            checks++;
            if (ad_q[a0+i] !== d) begin failures++; $display("FAIL load_addr base=%h idx=%0d: got %h required %h", base, i, ad_q[a0+i], d); end
         end
         if (s0 + i < wb_q.size()) begin
            checks++;
            if (wb_q[s0+i] !== 4'(1 << (i / 4))) begin failures++; $display("FAIL load_strobe base=%h idx=%0d: got %b required %b", base, i, wb_q[s0+i], 4'(1 << (i / 4))); end
            checks++;
            if (wd_q[s0+i] !== (32'(d) << (8 * (i / 4)))) begin failures++; $display("FAIL load_data base=%h idx=%0d: got %h required %h", base, i, wd_q[s0+i], 32'(d) << (8 * (i / 4))); end
         end
      end
      repeat (2) @(posedge clk);
      #1;
      $display("test_load base=%h: latency=%0d strobes=%0d", base, cyc, wb_q.size() - s0);
   endtask

   task automatic test_repulse();
      int cyc, s0, d0;
      s0 = wb_q.size(); d0 = done_cnt;
      do_load(8'h40, 1, cyc);
      @(posedge clk); #1;
      checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL repulse_idle_after_done: busy got %b required 0", bus_if.busy); end
      repeat (25) @(posedge clk);
      #1;
      checks++; if (cyc != 19) begin failures++; $display("FAIL repulse_latency: got %0d required 19", cyc); end
      checks++; if (wb_q.size() - s0 != 16) begin failures++; $display("FAIL repulse_strobes: got %0d required 16", wb_q.size() - s0); end
      checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL repulse_done_count: got %0d required 1", done_cnt - d0); end
      $display("test_repulse: latency=%0d strobes=%0d dones=%0d", cyc, wb_q.size() - s0, done_cnt - d0);
   endtask

   task automatic test_mid_reset();
      int s0, d0;
      s0 = wb_q.size(); d0 = done_cnt;
      bus_if.base_addr = 8'h20;
      bus_if.start = 1'b1;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (bus_if.ram_rd !== 1'b0) begin failures++; $display("FAIL midrst_ram_rd: got %b required 0", bus_if.ram_rd); end
      checks++; if (bus_if.ram_addr !== 8'h00) begin failures++; $display("FAIL midrst_ram_addr: got %h required 00", bus_if.ram_addr); end
      checks++; if (bus_if.write_bus !== 4'h0) begin failures++; $display("FAIL midrst_write_bus: got %b required 0000", bus_if.write_bus); end
      checks++; if (bus_if.weight_bus !== 32'h0) begin failures++; $display("FAIL midrst_weight_bus: got %h required 0", bus_if.weight_bus); end
      checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b required 0", bus_if.busy); end
      checks++; if (bus_if.done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b required 0", bus_if.done); end
      repeat (25) @(posedge clk);
      #1;
      checks++; if (wb_q.size() - s0 != 4) begin failures++; $display("FAIL midrst_strobes: got %0d required 4", wb_q.size() - s0); end
      checks++; if (done_cnt != d0) begin failures++; $display("FAIL midrst_no_done: got %0d required 0", done_cnt - d0); end
      $display("test_mid_reset: strobes before abort=%0d", wb_q.size() - s0);
      test_load(8'h30);
   endtask

   task automatic test_back_to_back();
      int cyc1, cyc2, s0, d0;
      logic [7:0] d;
      s0 = wb_q.size(); d0 = done_cnt;
      do_load(8'h50, 0, cyc1);
      bus_if.base_addr = 8'h99;
      bus_if.start = 1'b1;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL b2b_done_cycle_start: busy got %b required 0", bus_if.busy); end
      do_load(8'h50, 0, cyc2);
      @(negedge clk); #1;
      checks++; if (cyc1 != 19) begin failures++; $display("FAIL b2b_latency1: got %0d required 19", cyc1); end
      checks++; if (cyc2 != 19) begin failures++; $display("FAIL b2b_latency2: got %0d required 19", cyc2); end
      checks++; if (wb_q.size() - s0 != 32) begin failures++; $display("FAIL b2b_strobes: got %0d required 32", wb_q.size() - s0); end
      checks++; if (done_cnt - d0 != 2) begin failures++; $display("FAIL b2b_done_count: got %0d required 2", done_cnt - d0); end
      for (int i = 0; i < 32; i++) begin
         d = 8'(8'h50 + 8'(i % 16));
         if (s0 + i < wb_q.size()) begin
            checks++;
            if (wd_q[s0+i] !== (32'(d) << (8 * ((i % 16) / 4)))) begin failures++; $display("FAIL b2b_data idx=%0d: got %h required %h", i, wd_q[s0+i], 32'(d) << (8 * ((i % 16) / 4))); end
         end
      end
      repeat (2) @(posedge clk);
      #1;
      $display("test_back_to_back: latencies=%0d,%0d strobes=%0d", cyc1, cyc2, wb_q.size() - s0);
   endtask

`ifdef WEIGHT_DISPATCH_BROADCAST_EN
   task automatic test_broadcast();
      int cyc, s0;
      logic [7:0] d;
      s0 = wb_q.size();
      bus_if.broadcast = 1'b1;
      do_load(8'h00, 0, cyc);
      bus_if.broadcast = 1'b0;
      @(negedge clk); #1;
      checks++; if (cyc != 7) begin failures++; $display("FAIL bcast_latency: got %0d required 7", cyc); end
      checks++; if (wb_q.size() - s0 != 4) begin failures++; $display("FAIL bcast_strobes: got %0d required 4", wb_q.size() - s0); end
      for (int i = 0; i < 4; i++) begin
         d = 8'(i);
         if (s0 + i < wb_q.size()) begin
            checks++;
            if (wb_q[s0+i] !== 4'hF) begin failures++; $display("FAIL bcast_strobe idx=%0d: got %b required 1111", i, wb_q[s0+i]); end
            checks++;
            if (wd_q[s0+i] !== {4{d}}) begin failures++; $display("FAIL bcast_data idx=%0d: got %h required %h", i, wd_q[s0+i], {4{d}}); end
         end
      end
      repeat (2) @(posedge clk);
      #1;
      $display("test_broadcast: latency=%0d strobes=%0d", cyc, wb_q.size() - s0);
      test_load(8'h10);
   endtask
`endif

   initial begin
      bus_if.start = 1'b0;
      bus_if.base_addr = 8'h00;
`ifdef WEIGHT_DISPATCH_BROADCAST_EN
      bus_if.broadcast = 1'b0;
`endif
      test_reset();
      test_load(8'h10);
      test_load(8'hFA);
      test_repulse();
      test_mid_reset();
      test_back_to_back();
`ifdef WEIGHT_DISPATCH_BROADCAST_EN
      test_broadcast();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/weight_dispatch.md
Name: weight_dispatch

Overview:
- Parametrised successor to the four-unit RAM-to-unit weight demux.
- On `start`, autonomously reads a block of `NUM_UNITS*WPU` weights from the weight RAM, starting at a latched base address.
- Routes each weight, with a one-hot write strobe, to its target neuron unit: weights 0..WPU-1 go to unit 0, the next WPU to unit 1, and so on.
- Sits between the weight RAM and the neuron-unit array. Replaces externally driven unit selection with an internal address/unit sequencer.

Parameters:
- NUM_UNITS, 4: number of neuron units fed; must be ≥1.
- DATA_W, 8: weight width in bits.
- WPU, 16: weights per unit; must be ≥1.
- ADDR_W, 8: RAM address width; must be ≥ ceil(log2(NUM_UNITS*WPU)).

Ports:
- CLOCK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- start  input  1  one-cycle load request; sampled only in IDLE.
- base_addr  input  ADDR_W  first RAM address; latched when start is accepted.
- ram_addr  output  ADDR_W  RAM read address.
- ram_rd  output  1  RAM read enable.
- ram_out  input  DATA_W  RAM read data; valid exactly one cycle after ram_rd.
- weight_bus  output  NUM_UNITS*DATA_W  unit u occupies bits [u*DATA_W +: DATA_W].
- write_bus  output  NUM_UNITS  bit u = write strobe for unit u; one-hot or zero.
- busy  output  1  high in ISSUE and DRAIN.
- done  output  1  one-cycle pulse when the block load completes.

Behaviour:
- Clock and reset: one clock, CLOCK. Reset is synchronous and active-high, named RESET.
- Reset state: IDLE. ram_addr=0, ram_rd=0, weight_bus=0, write_bus=0, busy=0, done=0. All counters and pipeline registers cleared.
- Reset mid-operation: the load is abandoned, no further strobes issue, and done is not pulsed.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 → latch base_addr, clear the weight counter k and unit counter u, go to ISSUE.
  - start in any other state is ignored; requests are not queued.
- ISSUE: lasts exactly TOTAL=NUM_UNITS*WPU cycles.
  - Each cycle: ram_rd=1, ram_addr=base+k (mod 2^ADDR_W; wrap-around permitted), tag=u.
  - k increments every cycle. u increments when the per-unit counter reaches WPU-1.
  - After k=TOTAL-1, go to DRAIN.
- DRAIN: exactly 2 cycles with ram_rd=0, then go to DONE.
- DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Pipeline:
  - A read issued in cycle t returns ram_out in t+1.
  - In t+2, weight_bus slot tag carries that data and write_bus[tag]=1.
  - All other slots and strobes are 0 in that cycle, as before.
  - Latency from ram_rd to strobe is 2 cycles.
  - In cycles with no valid data, weight_bus=0 and write_bus=0.
- Strobe timing: the last strobe coincides with the second DRAIN cycle, and done follows in the next cycle.
- Cycle count: start-accept edge to done = TOTAL+3 cycles. A new start is accepted in the cycle after done.
- Counters: k is wide enough for TOTAL, and u for NUM_UNITS. Tags never exceed NUM_UNITS-1.

Optional Feature:
- Macro: WEIGHT_DISPATCH_BROADCAST_EN.
- When defined:
  - Adds an input `broadcast` (1 bit), latched with start.
  - If latched high, ISSUE lasts WPU cycles, reading base..base+WPU-1.
  - Each returned weight is driven on every weight_bus slot, with write_bus all ones.
  - DRAIN and DONE are unchanged, so the start-to-done time is WPU+3 cycles.
  - If latched low, behaviour is identical to the non-broadcast case.
- When undefined: the port is absent and behaviour is exactly as in Behaviour.

Test Plan:
- NUM_UNITS=4, WPU=4, base_addr=0x10, RAM[a]=a → 16 strobes:
  - Unit 0 receives 0x10..0x13, unit 1 receives 0x14..0x17, unit 2 receives 0x18..0x1B, unit 3 receives 0x1C..0x1F.
  - Strobes are one-hot with zero elsewhere.
  - done occurs exactly 19 cycles after start.
- base_addr=0xFA, ADDR_W=8 → ram_addr sequence 0xFA..0xFF, 0x00..0x09; data routing as above.
- start re-pulsed during ISSUE and DRAIN → ignored: a single done, and exactly 16 strobes.
- RESET asserted on the 6th ISSUE cycle → next cycle all outputs are 0, state is IDLE, and there are no strobes or done. A later start performs a full, correct load.
- Back-to-back: start in the cycle after done → accepted; second load is identical. start asserted in the DONE cycle → ignored.
- WEIGHT_DISPATCH_BROADCAST_EN with broadcast=1, base=0 → 4 reads. Each strobe has write_bus=4'b1111 and all slots equal to RAM[k]; done 7 cycles after start.
